bcd_seg_scan: RTL and testbench

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

---
 rtl/bcd_seg_scan.sv | 147 ++++++++++++++
 tb/tb_bcd_seg_scan.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 3-digit seven-segment driver with a one-deep pending buffer.
// The display value changes only on frame boundaries so a frame never mixes two values.
module bcd_seg_scan #(
    parameter int DIV         = 50000,
    parameter bit BLANK_LZ    = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd,
    input  logic        bcd_vld,
    output logic        bcd_rdy,
    output logic [6:0]  seg,
    output logic [2:0]  dig_en,
    output logic        frame_done
);

    localparam int              CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [6:0]       SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;

    // Active-high glyph for one nibble; anything above 9 shows a dash.
    function automatic logic [6:0] seg7_enc(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] hi);
        return SEG_ACT_LOW ? ~hi : hi;
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       idx_r;
    logic [11:0]      pend_r;
    logic             pend_full_r;
    logic [11:0]      disp_r;
    logic [6:0]       seg_r;
    logic [2:0]       dig_en_r;
    logic             frame_done_r;

    logic             tick_s;
    logic             boundary_s;
    logic             bcd_rdy_s;
    logic [3:0]       nib_s;
    logic             blank_s;
    logic [6:0]       seg_nxt_s;
    logic [2:0]       dig_en_nxt_s;

    assign bcd_rdy_s  = !pend_full_r && !rst;
    assign bcd_rdy    = bcd_rdy_s;
    assign seg        = seg_r;
    assign dig_en     = dig_en_r;
    assign frame_done = frame_done_r;

    // Slot timing and next segment/digit pattern for the current slot.
    always_comb begin
        tick_s       = (cnt_r == CNT_MAX);
        boundary_s   = tick_s && (idx_r == 2'd2);
        nib_s        = 4'h0;
        blank_s      = 1'b0;
        dig_en_nxt_s = 3'b000;
        case (idx_r)
            2'd0: begin
                nib_s        = disp_r[3:0];
                dig_en_nxt_s = 3'b001;
            end
            2'd1: begin
                nib_s        = disp_r[7:4];
                blank_s      = BLANK_LZ && (disp_r[11:4] == 8'h00);
                dig_en_nxt_s = 3'b010;
            end
            2'd2: begin
                nib_s        = disp_r[11:8];
                blank_s      = BLANK_LZ && (disp_r[11:8] == 4'h0);
                dig_en_nxt_s = 3'b100;
            end
            default: begin
                blank_s      = 1'b1;
                dig_en_nxt_s = 3'b000;
            end
        endcase
        if (blank_s) begin
            seg_nxt_s = SEG_OFF;
        end else begin
            seg_nxt_s = seg_pol(seg7_enc(nib_s));
        end
    end

    // Prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else begin
            if (tick_s) begin
                cnt_r <= '0;
                idx_r <= (idx_r == 2'd2) ? 2'd0 : idx_r + 2'd1;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Pending buffer and display register; capture and load never coincide
    // because capture needs an empty buffer and load needs a full one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r      <= 12'h000;
            pend_full_r <= 1'b0;
            disp_r      <= 12'h000;
        end else if (bcd_vld && bcd_rdy_s) begin
            pend_r      <= bcd;
            pend_full_r <= 1'b1;
        end else if (boundary_s && pend_full_r) begin
            disp_r      <= pend_r;
            pend_full_r <= 1'b0;
        end
    end

    // Registered display outputs and frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r        <= SEG_OFF;
            dig_en_r     <= 3'b000;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_nxt_s;
            dig_en_r     <= dig_en_nxt_s;
            frame_done_r <= boundary_s;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan (DIV=4, active-low segments); two instances
// differ only in BLANK_LZ and share stimulus, so each slot carries two expected glyphs.
module tb_bcd_seg_scan;

    typedef struct packed {
        logic [2:0] de;
        logic [6:0] sa;
        logic [6:0] sb;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd;
    logic        bcd_vld;
    logic        rdy_a, rdy_b;
    logic [6:0]  seg_a, seg_b;
    logic [2:0]  dig_en_a, dig_en_b;
    logic        fd_a, fd_b;

    int    checks   = 0;
    int    failures = 0;
    int    k        = 0;
    slot_t sb_q[$];
    logic [2:0] prev_de    = 3'b000;
    logic [6:0] prev_seg_a = 7'h00;
    logic [6:0] prev_seg_b = 7'h00;

    always #5 clk = ~clk;

    bcd_seg_scan #(.DIV(4), .BLANK_LZ(1'b1), .SEG_ACT_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bcd(bcd), .bcd_vld(bcd_vld), .bcd_rdy(rdy_a),
        .seg(seg_a), .dig_en(dig_en_a), .frame_done(fd_a)
    );

    bcd_seg_scan #(.DIV(4), .BLANK_LZ(1'b0), .SEG_ACT_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .bcd(bcd), .bcd_vld(bcd_vld), .bcd_rdy(rdy_b),
        .seg(seg_b), .dig_en(dig_en_b), .frame_done(fd_b)
    );

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_slot(input logic [2:0] de, input logic [6:0] sa, input logic [6:0] sb);
        slot_t e;
        e.de = de;
        e.sa = sa;
        e.sb = sb;
        sb_q.push_back(e);
    endtask

    // Expected glyphs for ones, tens, hundreds of one frame: a = blanking on, b = off.
    task automatic push_frame(input logic [6:0] oa, input logic [6:0] ta, input logic [6:0] ha,
                              input logic [6:0] ob, input logic [6:0] tb, input logic [6:0] hb);
        push_slot(3'b001, oa, ob);
        push_slot(3'b010, ta, tb);
        push_slot(3'b100, ha, hb);
    endtask

    // Advance one clock; frame_done must pulse on every 12th cycle after release.
    task automatic step();
        logic was_rst;
        was_rst = rst;
        @(posedge clk);
        #1;
        if (!was_rst) k++;
        chk("frame_done_a", {11'd0, fd_a}, (!was_rst && (k % 12 == 0)) ? 12'd1 : 12'd0);
        chk("frame_done_b", {11'd0, fd_b}, (!was_rst && (k % 12 == 0)) ? 12'd1 : 12'd0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_seg_a", {5'd0, seg_a}, 12'h07F);
        chk("rst_seg_b", {5'd0, seg_b}, 12'h07F);
        chk("rst_dig_en", {9'd0, dig_en_a}, 12'h000);
        chk("rst_rdy", {11'd0, rdy_a}, 12'h000);
        chk("rst_frame_done", {11'd0, fd_a}, 12'h000);
    endtask

    task automatic chk_rdy(input string name, input logic exp);
        chk(name, {11'd0, rdy_a}, {11'd0, exp});
        chk({name, "_b"}, {11'd0, rdy_b}, {11'd0, exp});
    endtask

    // Monitor: each new digit slot pops one expected entry; within a slot the glyph must hold.
    always @(negedge clk) begin
        if (dig_en_a != prev_de && dig_en_a != 3'b000) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL slot_unexpected actual dig_en=%b seg=%h expected no slot", dig_en_a, seg_a);
            end else begin
                chk("slot_dig_en_a", {9'd0, dig_en_a}, {9'd0, sb_q[0].de});
                chk("slot_dig_en_b", {9'd0, dig_en_b}, {9'd0, sb_q[0].de});
                chk("slot_seg_a", {5'd0, seg_a}, {5'd0, sb_q[0].sa});
                chk("slot_seg_b", {5'd0, seg_b}, {5'd0, sb_q[0].sb});
                void'(sb_q.pop_front());
            end
        end else if (dig_en_a == prev_de && dig_en_a != 3'b000) begin
            chk("seg_hold_a", {5'd0, seg_a}, {5'd0, prev_seg_a});
            chk("seg_hold_b", {5'd0, seg_b}, {5'd0, prev_seg_b});
        end
        prev_de    <= dig_en_a;
        prev_seg_a <= seg_a;
        prev_seg_b <= seg_b;
    end

    initial begin
        rst     = 1'b1;
        bcd     = 12'h000;
        bcd_vld = 1'b0;
        steps(3);
        chk_reset_outputs();
        rst = 1'b0;
        k   = 0;
        #1;
        chk_rdy("rdy_after_release", 1'b1);

        // Frame 0: shows 000; 255 captured on the first cycle.
        push_frame(7'h40, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);
        bcd = 12'h255; bcd_vld = 1'b1;
        step();
        bcd_vld = 1'b0;
        chk_rdy("rdy_after_capture", 1'b0);
        steps(11);
        chk_rdy("rdy_after_load", 1'b1);

        // Frame 1: shows 255; 007 captured.
        push_frame(7'h12, 7'h12, 7'h24, 7'h12, 7'h12, 7'h24);
        bcd = 12'h007; bcd_vld = 1'b1;
        step();
        bcd_vld = 1'b0;
        steps(11);

        // Frame 2: shows 007; 0A9 captured.
        push_frame(7'h78, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h40);
        bcd = 12'h0A9; bcd_vld = 1'b1;
        step();
        bcd_vld = 1'b0;
        steps(11);

        // Frame 3: shows 0A9; 123 captured on the boundary cycle itself.
        push_frame(7'h10, 7'h3F, 7'h7F, 7'h10, 7'h3F, 7'h40);
        steps(11);
        bcd = 12'h123; bcd_vld = 1'b1;
        chk_rdy("rdy_before_boundary", 1'b1);
        step();
        bcd = 12'h456;
        chk_rdy("rdy_stall_456", 1'b0);

        // Frame 4: still 0A9 (123 waits for the next boundary); 456 stalled.
        push_frame(7'h10, 7'h3F, 7'h7F, 7'h10, 7'h3F, 7'h40);
        steps(6);
        chk_rdy("rdy_stall_mid", 1'b0);
        steps(6);
        chk_rdy("rdy_after_123_load", 1'b1);

        // Frame 5: shows 123 for a full frame; 456 accepted on its first cycle.
        push_frame(7'h30, 7'h24, 7'h79, 7'h30, 7'h24, 7'h79);
        step();
        bcd_vld = 1'b0;
        chk_rdy("rdy_after_456", 1'b0);
        steps(11);

        // Frame 6: shows 456; 789 pending, then reset mid-frame during tens slot.
        push_slot(3'b001, 7'h02, 7'h02);
        push_slot(3'b010, 7'h12, 7'h12);
        bcd = 12'h789; bcd_vld = 1'b1;
        step();
        bcd_vld = 1'b0;
        chk_rdy("rdy_pending_789", 1'b0);
        steps(5);
        rst = 1'b1;
        #1;
        chk_rdy("rdy_in_reset", 1'b0);
        step();
        chk_reset_outputs();
        rst = 1'b0;
        k   = 0;

        // Frames 7-8: restart from 000; the discarded 789 must never appear.
        push_frame(7'h40, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);
        steps(12);
        push_frame(7'h40, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);
        steps(12);

        chk("sb_empty", sb_q.size()[11:0], 12'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
